dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data RAM between the SCPU data port (master 0) and the debug/loader port (master 1, e.g. a UART program loader or debug memory peek/poke).
- Sits between the requesters and the RAM instance on the memory clock domain.
- Grants at most one access per cycle with round-robin fairness.
- Routes read data back to the correct requester after the fixed RAM read latency.
- Keeps per-master grant counters for chip_debug outputs.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data RAM between the SCPU data port (master 0) and
// the debug/loader port (master 1). At most one access is granted per cycle
// using round-robin priority. Read data is steered back to the requester after
// the fixed RAM read latency. Per-master saturating grant counters are exported.
//
// Ports:
//   clk, rst                      memory clock, synchronous active-high reset
//   m0_* / m1_*                   requester ports: req/we/addr/wdata in,
//                                 gnt/rvalid/rdata out
//   ram_we, ram_addr, ram_wdata   RAM command, driven from the granted master
//   ram_rdata                     RAM read data, valid RD_LAT cycles after address
//   gnt_cnt0, gnt_cnt1            saturating grant counts per master
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);

    // last_gnt: 0 = master 0 won the last grant, 1 = master 1.
    // Resets to 1 so master 0 wins the first contention.
    logic              last_gnt;
    logic              rd_push;
    // Read tag pipeline: valid bit and requester id per stage.
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] id_pipe;
    logic              tail_vld;
    logic              tail_id;

    // Combinational grant: a lone requester always wins, and on contention
    // the master that did not win last time goes first.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            m0_gnt = m0_req && (!m1_req || last_gnt);
            m1_gnt = m1_req && (!m0_req || !last_gnt);
        end
    end

    // RAM command mux. With no grant the master 0 values are presented,
    // and ram_we stays low.
    always_comb begin
        ram_addr  = m1_gnt ? m1_addr  : m0_addr;
        ram_wdata = m1_gnt ? m1_wdata : m0_wdata;
        ram_we    = (m0_gnt && m0_we) || (m1_gnt && m1_we);
    end

    assign rd_push = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);

    // Round-robin state moves only on a grant. Idle cycles keep the priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (m0_gnt || m1_gnt) begin
            last_gnt <= m1_gnt;
        end
    end

    // Each granted read enters the tag pipeline, and writes and idle cycles
    // enter as bubbles. A reset flushes it, which discards reads still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= rd_push;
            id_pipe[0]  <= m1_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign tail_vld = vld_pipe[RD_LAT-1];
    assign tail_id  = id_pipe[RD_LAT-1];

    // The tail of the pipeline lines up with ram_rdata for that access.
    // This output is held low during reset.
    always_comb begin
        m0_rvalid = !rst && tail_vld && !tail_id;
        m1_rvalid = !rst && tail_vld && tail_id;
        m0_rdata  = m0_rvalid ? ram_rdata : '0;
        m1_rdata  = m1_rvalid ? ram_rdata : '0;
    end

    // The grant counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (m0_gnt && (gnt_cnt0 != {CNT_W{1'b1}}))
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (m1_gnt && (gnt_cnt1 != {CNT_W{1'b1}}))
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter.
// Instance A uses RD_LAT=1 and CNT_W=16, and is driven from a table of
// per-cycle vectors. Instance B uses RD_LAT=2 and CNT_W=4, and is driven by
// hand-written multi-cycle sequences: back-to-back reads, a reset while a read
// is in flight, and counter saturation.
// Each instance has a simple behavioural RAM with the matching read latency.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- instance A: RD_LAT=1, CNT_W=16 ----------------
    logic        a_rst;
    logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_ram_we;
    logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic [15:0] a_cnt0, a_cnt1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(a_rst),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .gnt_cnt0(a_cnt0), .gnt_cnt1(a_cnt1)
    );

    // RAM model A: read-first, 1-cycle read latency.
    logic [31:0] mem_a [0:255];
    always @(posedge clk) begin
        a_ram_rdata <= mem_a[a_ram_addr[9:2]];
        if (a_ram_we) mem_a[a_ram_addr[9:2]] <= a_ram_wdata;
    end

    // ---------------- instance B: RD_LAT=2, CNT_W=4 ----------------
    logic        b_rst;
    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_ram_we;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic [3:0]  b_cnt0, b_cnt1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(b_rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .gnt_cnt0(b_cnt0), .gnt_cnt1(b_cnt1)
    );

    // RAM model B: read-first, 2-cycle read latency.
    logic [31:0] mem_b [0:255];
    logic [31:0] b_stage;
    always @(posedge clk) begin
        b_stage     <= mem_b[b_ram_addr[9:2]];
        b_ram_rdata <= b_stage;
        if (b_ram_we) mem_b[b_ram_addr[9:2]] <= b_ram_wdata;
    end

    // ---------------- vector table for instance A ----------------
    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, we;
        logic [31:0] addr;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
        logic [15:0] c0, c1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic g0, input logic g1, input logic we,
                       input logic [31:0] addr, input logic rv0, input logic [31:0] rd0,
                       input logic rv1, input logic [31:0] rd1, input logic [15:0] c0,
                       input logic [15:0] c1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.we = we; v.addr = addr;
        v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1; v.c0 = c0; v.c1 = c1;
        vecs.push_back(v);
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] CF = 32'hCAFEF00D;
    localparam logic [31:0] WD = 32'h12345678;

    // Drive B inputs at the falling edge. Outputs are sampled 1ns later, away from posedge.
    task automatic b_drive(input logic rst, input logic r0, input logic [31:0] a0, input logic r1);
        @(negedge clk);
        b_rst = rst;
        b_m0_req = r0; b_m0_we = 1'b0; b_m0_addr = a0; b_m0_wdata = '0;
        b_m1_req = r1; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[8'h04] = DB;              // byte 0x10
        mem_a[8'h05] = CF;              // byte 0x14
        mem_b[8'h00] = 32'h11111111;    // byte 0x0
        mem_b[8'h01] = 32'h22222222;    // byte 0x4
        mem_b[8'h02] = 32'h33333333;    // byte 0x8

        //   rst r0 w0 a0     d0  r1 w1 a1     d1  | g0 g1 we addr  rv0 rd0 rv1 rd1  c0 c1
        add(0, 0,0,32'h00,0,  0,0,32'h00,0,   0,0,0,32'h00, 0,0, 0,0,  0,0); // v0 idle
        add(0, 1,0,32'h10,0,  0,0,32'h00,0,   1,0,0,32'h10, 0,0, 0,0,  0,0); // v1 m0 read only
        add(0, 0,0,32'h00,0,  0,0,32'h00,0,   0,0,0,32'h00, 1,DB,0,0,  1,0); // v2 return
        add(0, 0,0,32'h00,0,  0,0,32'h00,0,   0,0,0,32'h00, 0,0, 0,0,  1,0); // v3 single pulse
        add(1, 1,0,32'h10,0,  1,0,32'h14,0,   0,0,0,32'h10, 0,0, 0,0,  1,0); // v4 in reset
        add(0, 1,0,32'h10,0,  1,0,32'h14,0,   1,0,0,32'h10, 0,0, 0,0,  0,0); // v5 contention
        add(0, 1,0,32'h10,0,  1,0,32'h14,0,   0,1,0,32'h14, 1,DB,0,0,  1,0);
        add(0, 1,0,32'h10,0,  1,0,32'h14,0,   1,0,0,32'h10, 0,0, 1,CF, 1,1);
        add(0, 1,0,32'h10,0,  1,0,32'h14,0,   0,1,0,32'h14, 1,DB,0,0,  2,1);
        add(0, 1,0,32'h10,0,  1,0,32'h14,0,   1,0,0,32'h10, 0,0, 1,CF, 2,2);
        add(0, 1,0,32'h10,0,  1,0,32'h14,0,   0,1,0,32'h14, 1,DB,0,0,  3,2);
        add(0, 0,0,32'h00,0,  0,0,32'h00,0,   0,0,0,32'h00, 0,0, 1,CF, 3,3); // v11
        add(0, 0,0,32'h00,0,  1,1,32'h20,WD,  0,1,1,32'h20, 0,0, 0,0,  3,3); // v12 m1 write
        add(0, 1,0,32'h20,0,  0,0,32'h00,0,   1,0,0,32'h20, 0,0, 0,0,  3,4); // v13 m0 read
        add(0, 0,0,32'h00,0,  0,0,32'h00,0,   0,0,0,32'h00, 1,WD,0,0,  4,4); // v14
        add(0, 0,0,32'h00,0,  1,0,32'h10,0,   0,1,0,32'h10, 0,0, 0,0,  4,4); // v15 m1 read
        add(1, 0,0,32'h00,0,  0,0,32'h00,0,   0,0,0,32'h00, 0,0, 0,0,  4,5); // v16 reset
        add(0, 1,0,32'h10,0,  1,0,32'h14,0,   1,0,0,32'h10, 0,0, 0,0,  0,0); // v17 m0 first
        add(0, 0,0,32'h00,0,  0,0,32'h00,0,   0,0,0,32'h00, 1,DB,0,0,  1,0);
        add(0, 0,0,32'h00,0,  0,0,32'h00,0,   0,0,0,32'h00, 0,0, 0,0,  1,0); // v19 idle keeps prio
        add(0, 1,0,32'h10,0,  1,0,32'h14,0,   0,1,0,32'h14, 0,0, 0,0,  1,0); // v20 m1 wins
        add(0, 0,0,32'h00,0,  0,0,32'h00,0,   0,0,0,32'h00, 0,0, 1,CF, 1,1);

        // Start both instances in reset.
        a_rst = 1'b1; b_rst = 1'b1;
        a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
        a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0;
        b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
        b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            a_rst = vecs[i].rst;
            a_m0_req = vecs[i].r0; a_m0_we = vecs[i].w0;
            a_m0_addr = vecs[i].a0; a_m0_wdata = vecs[i].d0;
            a_m1_req = vecs[i].r1; a_m1_we = vecs[i].w1;
            a_m1_addr = vecs[i].a1; a_m1_wdata = vecs[i].d1;
            #1;
            check($sformatf("v%0d.m0_gnt", i),    {31'b0, a_m0_gnt},    {31'b0, vecs[i].g0});
            check($sformatf("v%0d.m1_gnt", i),    {31'b0, a_m1_gnt},    {31'b0, vecs[i].g1});
            check($sformatf("v%0d.ram_we", i),    {31'b0, a_ram_we},    {31'b0, vecs[i].we});
            check($sformatf("v%0d.ram_addr", i),  a_ram_addr,           vecs[i].addr);
            check($sformatf("v%0d.m0_rvalid", i), {31'b0, a_m0_rvalid}, {31'b0, vecs[i].rv0});
            check($sformatf("v%0d.m0_rdata", i),  a_m0_rdata,           vecs[i].rd0);
            check($sformatf("v%0d.m1_rvalid", i), {31'b0, a_m1_rvalid}, {31'b0, vecs[i].rv1});
            check($sformatf("v%0d.m1_rdata", i),  a_m1_rdata,           vecs[i].rd1);
            check($sformatf("v%0d.gnt_cnt0", i),  {16'b0, a_cnt0},      {16'b0, vecs[i].c0});
            check($sformatf("v%0d.gnt_cnt1", i),  {16'b0, a_cnt1},      {16'b0, vecs[i].c1});
            if (vecs[i].we)
                check($sformatf("v%0d.ram_wdata", i), a_ram_wdata, vecs[i].d1);
        end

        // ---- B: back-to-back m0 reads to 0x0, 0x4, 0x8 with RD_LAT=2 ----
        b_drive(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] exp_d;
            b_drive(1'b0, k < 3, 32'(4 * k), 1'b0);
            exp_d = (k == 2) ? 32'h11111111 : (k == 3) ? 32'h22222222 :
                    (k == 4) ? 32'h33333333 : 32'h0;
            check($sformatf("b2b%0d.m0_gnt", k),    {31'b0, b_m0_gnt},    {31'b0, k < 3});
            check($sformatf("b2b%0d.m0_rvalid", k), {31'b0, b_m0_rvalid}, {31'b0, k >= 2 && k <= 4});
            check($sformatf("b2b%0d.m0_rdata", k),  b_m0_rdata,           exp_d);
            check($sformatf("b2b%0d.m1_rvalid", k), {31'b0, b_m1_rvalid}, 32'h0);
        end

        // ---- B: reset while a read is in flight ----
        b_drive(1'b0, 1'b1, 32'h4, 1'b0);
        check("rst.grant_before", {31'b0, b_m0_gnt}, 32'h1);
        b_drive(1'b1, 1'b0, 32'h0, 1'b0);
        check("rst.gnt_in_reset", {30'b0, b_m0_gnt, b_m1_gnt}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            b_drive(1'b0, 1'b0, 32'h0, 1'b0);
            check($sformatf("rst%0d.m0_rvalid", k), {31'b0, b_m0_rvalid}, 32'h0);
            check($sformatf("rst%0d.m1_rvalid", k), {31'b0, b_m1_rvalid}, 32'h0);
            check($sformatf("rst%0d.cnt0", k),      {28'b0, b_cnt0},      32'h0);
            check($sformatf("rst%0d.cnt1", k),      {28'b0, b_cnt1},      32'h0);
        end
        b_drive(1'b0, 1'b1, 32'h0, 1'b1);
        check("rst.first_contention", {30'b0, b_m0_gnt, b_m1_gnt}, 32'h2);

        // ---- B: m1 counter saturates at 0xF (CNT_W=4) ----
        for (int k = 0; k < 20; k++) begin
            b_drive(1'b0, 1'b0, 32'h0, 1'b1);
            check($sformatf("sat%0d.m1_gnt", k), {31'b0, b_m1_gnt}, 32'h1);
            check($sformatf("sat%0d.cnt1", k),   {28'b0, b_cnt1},   (k > 15) ? 32'd15 : 32'(k));
        end
        b_drive(1'b0, 1'b0, 32'h0, 1'b0);
        check("sat.final_cnt1", {28'b0, b_cnt1}, 32'd15);
        check("sat.cnt0", {28'b0, b_cnt0}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
